// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Tag fields are sized for the largest supported requester count (8).
package mul_sched_pkg;

  localparam int DATA_W    = 32;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int MAX_REQ   = 8;
  localparam int TAG_MAX_W = 3;

  typedef struct packed {
    logic                 vld;
    logic [TAG_MAX_W-1:0] tag;
  } tag_stage_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [TAG_MAX_W-1:0] tag);
    onehot      = '0;
    onehot[tag] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request found by
// searching circularly upward from ptr.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  int cand;

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = 0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mul_rr_sched.sv
// Time-shares one external pipelined signed multiplier among NUM_REQ requesters,
// tagging each issue so its product is routed back to the right requester.
module mul_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = mul_sched_pkg::DATA_W,
  parameter int MUL_LAT = 6,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DATA_W-1:0]     mul_a,
  output logic [DATA_W-1:0]     mul_b,
  input  logic [2*DATA_W-1:0]   mul_p,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [2*DATA_W-1:0]   resp_p,
  output logic                  busy
);

  import mul_sched_pkg::*;

  logic [TAG_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               hs;
  logic [MAX_REQ-1:0] resp_oh;
  tag_stage_t         stages [MUL_LAT+1];

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = rst ? '0 : grant;
  assign hs        = |(req_valid & req_ready);
  assign resp_oh   = onehot(stages[MUL_LAT].tag);

  // The last tag stage lines up with mul_p for the operands issued MUL_LAT edges earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_valid <= '0;
      resp_p     <= '0;
      for (int i = 0; i <= MUL_LAT; i++) stages[i] <= '0;
    end else begin
      if (hs) begin
        ptr   <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        mul_a <= req_a[grant_idx*DATA_W +: DATA_W];
        mul_b <= req_b[grant_idx*DATA_W +: DATA_W];
      end
      stages[0] <= '{vld: hs, tag: TAG_MAX_W'(grant_idx)};
      for (int i = 1; i <= MUL_LAT; i++) stages[i] <= stages[i-1];
      if (stages[MUL_LAT].vld) begin
        resp_p     <= mul_p;
        resp_valid <= resp_oh[NUM_REQ-1:0];
      end else begin
        resp_valid <= '0;
      end
    end
  end

  always_comb begin
    busy = |resp_valid;
    for (int i = 0; i <= MUL_LAT; i++) busy = busy | stages[i].vld;
  end

endmodule
